// File: rtl/serial_mod_div_checker.sv
// Multi-channel serial divisibility checker: per-channel running remainder modulo DIVISOR, MSB- or LSB-first.
// Optional per-channel clear port enabled by defining SERIAL_MOD_CLEAR_EN.
module serial_mod_div_checker #(
    parameter int DIVISOR   = 3,
    parameter int CHANNELS  = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter int RW        = $clog2(DIVISOR)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [CHANNELS-1:0]    din,
    input  logic [CHANNELS-1:0]    din_valid,
    input  logic [CHANNELS-1:0]    sof,
`ifdef SERIAL_MOD_CLEAR_EN
    input  logic [CHANNELS-1:0]    clr,
`endif
    output logic [CHANNELS-1:0]    dout,
    output logic [CHANNELS*RW-1:0] rem,
    output logic [CHANNELS-1:0]    active
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);
    localparam logic [RW:0] TWO_W = (RW+1)'(2);

    // Inputs are always below 2*DIVISOR, so one conditional subtract suffices.
    function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] x);
        logic [RW:0] diff;
        diff = x - DIV_W;
        if (x >= DIV_W) begin
            return diff[RW-1:0];
        end
        return x[RW-1:0];
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [RW-1:0] rem_q, rem_d;
        logic [RW-1:0] w_q, w_d;
        logic          dout_q, dout_d;
        logic          start;
        logic          clr_c;

`ifdef SERIAL_MOD_CLEAR_EN
        assign clr_c = clr[i];
`else
        assign clr_c = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q <= IDLE;
                rem_q   <= '0;
                w_q     <= RW'(1);
                dout_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                w_q     <= w_d;
                dout_q  <= dout_d;
            end
        end

        always_comb begin
            state_d = state_q;
            if (clr_c) begin
                state_d = IDLE;
            end else if (din_valid[i]) begin
                state_d = ACTIVE;
            end
        end

        // The first bit after IDLE always starts a fresh number, sof or not.
        always_comb begin
            rem_d  = rem_q;
            w_d    = w_q;
            start  = sof[i] || (state_q == IDLE);
            if (clr_c) begin
                rem_d = '0;
                w_d   = RW'(1);
            end else if (din_valid[i]) begin
                if (MSB_FIRST) begin
                    rem_d = start ? RW'(din[i]) : mod_reduce({rem_q, din[i]});
                end else if (start) begin
                    rem_d = RW'(din[i]);
                    w_d   = mod_reduce(TWO_W);
                end else begin
                    rem_d = mod_reduce({1'b0, rem_q} + (din[i] ? {1'b0, w_q} : '0));
                    w_d   = mod_reduce({w_q, 1'b0});
                end
            end
            dout_d = (state_d == ACTIVE) && (rem_d == '0);
        end

        assign dout[i]              = dout_q;
        assign rem[i*RW +: RW]      = rem_q;
        assign active[i]            = (state_q == ACTIVE);
    end

endmodule
